// File: rtl/valu_retire_clear_arbiter_pkg.sv
// Shared definitions for the VALU retire clear arbiter: default GPR address widths and retire entry layout.
package valu_retire_clear_arbiter_pkg;

  localparam int VGPR_ADDR_LENGTH = 10;
  localparam int SGPR_ADDR_LENGTH = 9;

  // Entry layout, MSB first: vgpr_addr | vgpr_valid | sgpr_addr | sgpr_valid
  localparam int RETIRE_ENTRY_WIDTH   = VGPR_ADDR_LENGTH + SGPR_ADDR_LENGTH + 2;
  localparam int RETIRE_SGPR_VALID_LO = 0;
  localparam int RETIRE_SGPR_ADDR_LO  = 1;
  localparam int RETIRE_VGPR_VALID_LO = SGPR_ADDR_LENGTH + 1;
  localparam int RETIRE_VGPR_ADDR_LO  = SGPR_ADDR_LENGTH + 2;

  function automatic int retire_entry_width(int vaddr_w, int saddr_w);
    return vaddr_w + saddr_w + 2;
  endfunction

endpackage

// File: rtl/valu_retire_clear_arbiter_if.sv
// Retire-source / busy-table clear bundle. master = retire side and scoreboard, slave = arbiter.
interface valu_retire_clear_arbiter_if
  import valu_retire_clear_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int VADDR_W = VGPR_ADDR_LENGTH,
  parameter int SADDR_W = SGPR_ADDR_LENGTH
);
  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC-1:0]         src_ready;
  logic [NUM_SRC*VADDR_W-1:0] src_vgpr_addr;
  logic [NUM_SRC-1:0]         src_vgpr_valid;
  logic [NUM_SRC*SADDR_W-1:0] src_sgpr_addr;
  logic [NUM_SRC-1:0]         src_sgpr_valid;
  logic [VADDR_W-1:0]         f_vgpr_alu_dest_reg_addr;
  logic                       f_vgpr_alu_dest_reg_valid;
  logic [SADDR_W-1:0]         f_sgpr_valu_dest_addr;
  logic                       f_sgpr_valu_dest_reg_valid;
  logic                       retire_idle;

  modport master (
    output src_valid, src_vgpr_addr, src_vgpr_valid, src_sgpr_addr, src_sgpr_valid,
    input  src_ready, f_vgpr_alu_dest_reg_addr, f_vgpr_alu_dest_reg_valid,
           f_sgpr_valu_dest_addr, f_sgpr_valu_dest_reg_valid, retire_idle
  );

  modport slave (
    input  src_valid, src_vgpr_addr, src_vgpr_valid, src_sgpr_addr, src_sgpr_valid,
    output src_ready, f_vgpr_alu_dest_reg_addr, f_vgpr_alu_dest_reg_valid,
           f_sgpr_valu_dest_addr, f_sgpr_valu_dest_reg_valid, retire_idle
  );
endinterface

// File: rtl/valu_retire_clear_arbiter_retire_fifo.sv
// Per-source retire FIFO: power-of-two depth, wrapping pointers, registered occupancy count.
module retire_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/valu_retire_clear_arbiter.sv
// Collects VALU retire events per SIMD source and round-robins them onto the VGPR/SGPR busy-clear ports.
// Optional macro RETIRE_BYPASS_EN: with all FIFOs empty, the round-robin winner among new events skips its FIFO.
module valu_retire_clear_arbiter
  import valu_retire_clear_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int VADDR_W    = VGPR_ADDR_LENGTH,
  parameter int SADDR_W    = SGPR_ADDR_LENGTH
) (
  input logic                    clk,
  input logic                    rst,
  valu_retire_clear_arbiter_if.slave bus
);
  localparam int EW    = retire_entry_width(VADDR_W, SADDR_W);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PTR_W:0]   NSRC = (PTR_W+1)'(NUM_SRC);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_SRC - 1);

  typedef struct packed {
    logic [VADDR_W-1:0] vgpr_addr;
    logic               vgpr_valid;
    logic [SADDR_W-1:0] sgpr_addr;
    logic               sgpr_valid;
  } entry_t;

  logic [NUM_SRC-1:0][VADDR_W-1:0] vaddr;
  logic [NUM_SRC-1:0][SADDR_W-1:0] saddr;
  entry_t [NUM_SRC-1:0]            din, dout;
  logic [NUM_SRC-1:0][CW-1:0]      cnt;
  logic [NUM_SRC-1:0]              full, empty, accept, push, pop, sel_mask;

  logic [PTR_W-1:0] rr_ptr, win;
  logic [PTR_W:0]   sum;
  logic             win_vld, bypass, fifos_idle;
  entry_t           win_entry;

  logic               vgpr_vld_q, sgpr_vld_q;
  logic [VADDR_W-1:0] vgpr_addr_q;
  logic [SADDR_W-1:0] sgpr_addr_q;

  assign vaddr = bus.src_vgpr_addr;
  assign saddr = bus.src_sgpr_addr;

  // Ready looks only at the registered count, so a full FIFO being popped still shows not-ready.
  assign bus.src_ready = ~full;
  // Events retiring nothing are accepted but never stored.
  assign accept = bus.src_valid & ~full & (bus.src_vgpr_valid | bus.src_sgpr_valid);

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      din[i].vgpr_addr  = vaddr[i];
      din[i].vgpr_valid = bus.src_vgpr_valid[i];
      din[i].sgpr_addr  = saddr[i];
      din[i].sgpr_valid = bus.src_sgpr_valid[i];
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    retire_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din[i]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (cnt[i])
    );
  end

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    sel_mask = ~empty;
    bypass   = 1'b0;
`ifdef RETIRE_BYPASS_EN
    if (&empty && |accept) begin
      sel_mask = accept;
      bypass   = 1'b1;
    end
`endif
    win_vld = 1'b0;
    win     = '0;
    sum     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= NSRC) sum = sum - NSRC;
      if (!win_vld && sel_mask[sum[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win     = sum[PTR_W-1:0];
      end
    end
    push = accept;
    pop  = '0;
    if (win_vld) begin
      if (bypass) push[win] = 1'b0;
      else        pop[win]  = 1'b1;
    end
    win_entry = bypass ? din[win] : dout[win];
  end

  always_comb begin
    fifos_idle = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cnt[i] != '0) fifos_idle = 1'b0;
    end
  end

  // Valids pulse for one cycle per cleared event; each address holds until its own port fires again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      vgpr_vld_q  <= 1'b0;
      sgpr_vld_q  <= 1'b0;
      vgpr_addr_q <= '0;
      sgpr_addr_q <= '0;
    end else begin
      vgpr_vld_q <= win_vld & win_entry.vgpr_valid;
      sgpr_vld_q <= win_vld & win_entry.sgpr_valid;
      if (win_vld) rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
      if (win_vld && win_entry.vgpr_valid) vgpr_addr_q <= win_entry.vgpr_addr;
      if (win_vld && win_entry.sgpr_valid) sgpr_addr_q <= win_entry.sgpr_addr;
    end
  end

  assign bus.f_vgpr_alu_dest_reg_addr   = vgpr_addr_q;
  assign bus.f_vgpr_alu_dest_reg_valid  = vgpr_vld_q;
  assign bus.f_sgpr_valu_dest_addr      = sgpr_addr_q;
  assign bus.f_sgpr_valu_dest_reg_valid = sgpr_vld_q;
  assign bus.retire_idle                = fifos_idle & ~vgpr_vld_q & ~sgpr_vld_q;

endmodule

// File: tb/tb_valu_retire_clear_arbiter.sv
// Bench for valu_retire_clear_arbiter: directed vector table, corner sequences, random traffic vs a queue model.
module tb_valu_retire_clear_arbiter;
  localparam int N = 4, D = 4, VW = 10, SW = 9;
`ifdef RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  valu_retire_clear_arbiter_if #(.NUM_SRC(N), .VADDR_W(VW), .SADDR_W(SW)) bus();

  valu_retire_clear_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .VADDR_W(VW), .SADDR_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { bit [VW-1:0] va; bit [SW-1:0] sa; bit vv; bit sv; } ent_t;
  ent_t q[N][$];
  int rr;
  bit m_vv, m_sv;
  bit [VW-1:0] m_va;
  bit [SW-1:0] m_sa;

  typedef struct {
    logic [N-1:0] v, vv, sv;
    logic [N*VW-1:0] va;
    logic [N*SW-1:0] sa;
    logic [1:0] ev_n; logic [VW-1:0] va_n; logic [SW-1:0] sa_n; logic idle_n;
    logic [1:0] ev_b; logic [VW-1:0] va_b; logic [SW-1:0] sa_b; logic idle_b;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [N-1:0] v, logic [N-1:0] vv, logic [N-1:0] sv,
                       logic [N*VW-1:0] va, logic [N*SW-1:0] sa);
    bus.src_valid      = v;
    bus.src_vgpr_valid = vv;
    bus.src_sgpr_valid = sv;
    bus.src_vgpr_addr  = va;
    bus.src_sgpr_addr  = sa;
  endtask

  task automatic add(logic [N-1:0] v, logic [N-1:0] vv, logic [N-1:0] sv,
                     logic [N*VW-1:0] va, logic [N*SW-1:0] sa,
                     logic [1:0] ev_n, logic [VW-1:0] va_n, logic [SW-1:0] sa_n, logic idle_n,
                     logic [1:0] ev_b, logic [VW-1:0] va_b, logic [SW-1:0] sa_b, logic idle_b);
    vec_t r;
    r.v = v; r.vv = vv; r.sv = sv; r.va = va; r.sa = sa;
    r.ev_n = ev_n; r.va_n = va_n; r.sa_n = sa_n; r.idle_n = idle_n;
    r.ev_b = ev_b; r.va_b = va_b; r.sa_b = sa_b; r.idle_b = idle_b;
    tbl.push_back(r);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    rr = 0; m_vv = 0; m_sv = 0; m_va = '0; m_sa = '0;
  endtask

  function automatic int rr_pick(bit [N-1:0] mask, int ptr);
    for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic bit model_empty();
    for (int i = 0; i < N; i++) if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock edge of the behavioural model, from the inputs the DUT sees at that edge.
  task automatic model_edge();
    ent_t inc[N];
    ent_t e;
    bit [N-1:0] acc, ne;
    bit byp;
    int w;
    for (int i = 0; i < N; i++) begin
      inc[i].va = bus.src_vgpr_addr[i*VW +: VW];
      inc[i].sa = bus.src_sgpr_addr[i*SW +: SW];
      inc[i].vv = bus.src_vgpr_valid[i];
      inc[i].sv = bus.src_sgpr_valid[i];
      acc[i] = bus.src_valid[i] && (q[i].size() < D) && (inc[i].vv || inc[i].sv);
      ne[i]  = (q[i].size() != 0);
    end
    byp = BYP && (ne == '0) && (acc != '0);
    w = rr_pick(byp ? acc : ne, rr);
    m_vv = 0; m_sv = 0;
    if (w >= 0) begin
      e = byp ? inc[w] : q[w].pop_front();
      if (e.vv) begin m_vv = 1; m_va = e.va; end
      if (e.sv) begin m_sv = 1; m_sa = e.sa; end
      rr = (w + 1) % N;
    end
    for (int i = 0; i < N; i++) if (acc[i] && !(byp && i == w)) q[i].push_back(inc[i]);
  endtask

  // Inputs are already driven; check ready, take one edge, then check outputs on the falling edge.
  task automatic cycle();
    bit [N-1:0] er;
    for (int i = 0; i < N; i++) er[i] = (q[i].size() < D);
    chk("src_ready", bus.src_ready, er);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("vgpr_valid", bus.f_vgpr_alu_dest_reg_valid, m_vv);
    chk("sgpr_valid", bus.f_sgpr_valu_dest_reg_valid, m_sv);
    if (m_vv) chk("vgpr_addr", bus.f_vgpr_alu_dest_reg_addr, m_va);
    if (m_sv) chk("sgpr_addr", bus.f_sgpr_valu_dest_addr, m_sa);
    chk("retire_idle", bus.retire_idle, model_empty() && !m_vv && !m_sv);
  endtask

  task automatic run_table();
    vec_t r;
    logic [1:0] ev; logic [VW-1:0] eva; logic [SW-1:0] esa; logic eidle;
    for (int k = 0; k < tbl.size(); k++) begin
      r = tbl[k];
      drive(r.v, r.vv, r.sv, r.va, r.sa);
      cycle();
      ev = BYP ? r.ev_b : r.ev_n;
      eva = BYP ? r.va_b : r.va_n;
      esa = BYP ? r.sa_b : r.sa_n;
      eidle = BYP ? r.idle_b : r.idle_n;
      chk($sformatf("tbl%0d_vv", k), bus.f_vgpr_alu_dest_reg_valid, ev[1]);
      chk($sformatf("tbl%0d_sv", k), bus.f_sgpr_valu_dest_reg_valid, ev[0]);
      if (ev[1]) chk($sformatf("tbl%0d_va", k), bus.f_vgpr_alu_dest_reg_addr, eva);
      if (ev[0]) chk($sformatf("tbl%0d_sa", k), bus.f_sgpr_valu_dest_addr, esa);
      chk($sformatf("tbl%0d_idle", k), bus.retire_idle, eidle);
    end
  endtask

  // Source 1 streams 0x100..0x10F against three always-busy sources.
  task automatic run_full();
    int n, m;
    bit saw, acc1;
    logic [VW-1:0] a1;
    n = 0; m = 0; saw = 0;
    for (int c = 0; c < 300 && m < 16; c++) begin
      a1 = VW'(32'h100 + n);
      if (n < 16) drive(4'hF, 4'hF, 4'hF, {10'h303, 10'h302, a1, 10'h300}, {9'h3, 9'h2, 9'h1, 9'h0});
      else        drive(4'h0, 4'h0, 4'h0, '0, '0);
      if (!bus.src_ready[1]) saw = 1;
      acc1 = (n < 16) && (q[1].size() < D);
      cycle();
      if (acc1) n++;
      if (bus.f_vgpr_alu_dest_reg_valid && bus.f_vgpr_alu_dest_reg_addr >= 10'h100 &&
          bus.f_vgpr_alu_dest_reg_addr <= 10'h10F) begin
        chk("full_order", bus.f_vgpr_alu_dest_reg_addr, 64'h100 + 64'(m));
        m++;
      end
    end
    chk("full_count", m, 16);
    chk("full_ready_low", saw, 1);
    drive(4'h0, 4'h0, 4'h0, '0, '0);
    repeat (24) cycle();
  endtask

  task automatic run_mid_reset();
    drive(4'hF, 4'hF, 4'hF, {10'h333, 10'h222, 10'h111, 10'h0AA}, {9'h33, 9'h22, 9'h11, 9'h0AA});
    cycle();
    cycle();
    drive(4'h0, 4'h0, 4'h0, '0, '0);
    rst = 1'b1;
    #1;
    chk("mid_rst_vv", bus.f_vgpr_alu_dest_reg_valid, 0);
    chk("mid_rst_sv", bus.f_sgpr_valu_dest_reg_valid, 0);
    chk("mid_rst_va", bus.f_vgpr_alu_dest_reg_addr, 0);
    chk("mid_rst_sa", bus.f_sgpr_valu_dest_addr, 0);
    chk("mid_rst_ready", bus.src_ready, 4'hF);
    chk("mid_rst_idle", bus.retire_idle, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("mid_rst_no_clear", bus.f_vgpr_alu_dest_reg_valid | bus.f_sgpr_valu_dest_reg_valid, 0);
    end
  endtask

  task automatic run_random(int cyc);
    logic [N*VW-1:0] va;
    logic [N*SW-1:0] sa;
    logic [N-1:0] v;
    for (int c = 0; c < cyc; c++) begin
      for (int i = 0; i < N; i++) begin
        va[i*VW +: VW] = VW'($urandom);
        sa[i*SW +: SW] = SW'($urandom);
      end
      v = (c < cyc / 2) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      drive(v, N'($urandom), N'($urandom), va, sa);
      cycle();
    end
    drive(4'h0, 4'h0, 4'h0, '0, '0);
    repeat (30) cycle();
    chk("rand_drained_idle", bus.retire_idle, 1);
  endtask

  initial begin
    // Single event, null event, vgpr-only event, four-way round robin.
    add(4'b0100, 4'b0100, 4'b0100, {10'h0, 10'h0A5, 10'h0, 10'h0}, {9'h0, 9'h06A, 9'h0, 9'h0},
        2'b00, 10'h0, 9'h0, 1'b0,     2'b11, 10'h0A5, 9'h06A, 1'b0);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b11, 10'h0A5, 9'h06A, 1'b0,  2'b00, 10'h0, 9'h0, 1'b1);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b00, 10'h0, 9'h0, 1'b1,      2'b00, 10'h0, 9'h0, 1'b1);
    add(4'b0001, 4'b0000, 4'b0000, {10'h0, 10'h0, 10'h0, 10'h3FF}, {9'h0, 9'h0, 9'h0, 9'h1FF},
        2'b00, 10'h0, 9'h0, 1'b1,     2'b00, 10'h0, 9'h0, 1'b1);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b00, 10'h0, 9'h0, 1'b1,      2'b00, 10'h0, 9'h0, 1'b1);
    add(4'b1000, 4'b1000, 4'b0000, {10'h1C3, 10'h0, 10'h0, 10'h0}, {9'h1FF, 9'h0, 9'h0, 9'h0},
        2'b00, 10'h0, 9'h0, 1'b0,     2'b10, 10'h1C3, 9'h0, 1'b0);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b10, 10'h1C3, 9'h0, 1'b0,    2'b00, 10'h0, 9'h0, 1'b1);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b00, 10'h0, 9'h0, 1'b1,      2'b00, 10'h0, 9'h0, 1'b1);
    add(4'b1111, 4'b1111, 4'b1111, {10'h203, 10'h202, 10'h201, 10'h200}, {9'h043, 9'h042, 9'h041, 9'h040},
        2'b00, 10'h0, 9'h0, 1'b0,     2'b11, 10'h200, 9'h040, 1'b0);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b11, 10'h200, 9'h040, 1'b0,  2'b11, 10'h201, 9'h041, 1'b0);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b11, 10'h201, 9'h041, 1'b0,  2'b11, 10'h202, 9'h042, 1'b0);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b11, 10'h202, 9'h042, 1'b0,  2'b11, 10'h203, 9'h043, 1'b0);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b11, 10'h203, 9'h043, 1'b0,  2'b00, 10'h0, 9'h0, 1'b1);
    add(4'b0, 4'b0, 4'b0, '0, '0,  2'b00, 10'h0, 9'h0, 1'b1,      2'b00, 10'h0, 9'h0, 1'b1);

    drive(4'h0, 4'h0, 4'h0, '0, '0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_vv", bus.f_vgpr_alu_dest_reg_valid, 0);
    chk("rst_sv", bus.f_sgpr_valu_dest_reg_valid, 0);
    chk("rst_va", bus.f_vgpr_alu_dest_reg_addr, 0);
    chk("rst_sa", bus.f_sgpr_valu_dest_addr, 0);
    chk("rst_ready", bus.src_ready, 4'hF);
    chk("rst_idle", bus.retire_idle, 1);
    rst = 1'b0;

    run_table();
    run_full();
    run_mid_reset();
    run_random(600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
